// File: rtl/scanout_pkg.sv
// Shared types, palette and default panel timing for the frame scanout path.
package scanout_pkg;

  typedef logic [23:0] rgb_t;

  // Fixed 8-entry palette; index 0 is the background colour.
  localparam rgb_t PALETTE [8] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF
  };

  localparam int DEF_COOR_WIDTH   = 12;
  localparam int DEF_FRAME_WIDTH  = 1280;
  localparam int DEF_FRAME_HEIGHT = 300;
  localparam int DEF_VIEW_Y0      = 90;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic in_band;
    logic active;
    logic hsync_n;
    logic vsync_n;
  } pipe_ctl_t;

  localparam pipe_ctl_t PIPE_IDLE = '{in_band: 1'b0, active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/scanout_timing.sv
// Panel raster counters with active window, active-low sync windows and
// a one-cycle vblank-start strobe, all decoded from the current count.
module scanout_timing
  import scanout_pkg::*;
#(
  parameter int COOR_WIDTH = DEF_COOR_WIDTH,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  output logic [COOR_WIDTH-1:0] h_o,
  output logic [COOR_WIDTH-1:0] v_o,
  output logic                  active_o,
  output logic                  hsync_n_o,
  output logic                  vsync_n_o,
  output logic                  vblank_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COOR_WIDTH-1:0] H_LAST   = COOR_WIDTH'(H_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] V_LAST   = COOR_WIDTH'(V_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] H_ACT_C  = COOR_WIDTH'(H_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] V_ACT_C  = COOR_WIDTH'(V_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] HS_BEG_C = COOR_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COOR_WIDTH-1:0] HS_END_C = COOR_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COOR_WIDTH-1:0] VS_BEG_C = COOR_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COOR_WIDTH-1:0] VS_END_C = COOR_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [COOR_WIDTH-1:0] h_q, h_d;
  logic [COOR_WIDTH-1:0] v_q, v_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o            = h_q;
  assign v_o            = v_q;
  assign active_o       = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hsync_n_o      = !((h_q >= HS_BEG_C) && (h_q < HS_END_C));
  assign vsync_n_o      = !((v_q >= VS_BEG_C) && (v_q < VS_END_C));
  assign vblank_start_o = (h_q == '0) && (v_q == V_ACT_C);

endmodule

// File: rtl/frame_scanout.sv
// Frame buffer scanout: address generation, 2-stage RAM/palette pipeline,
// per-frame scroll latch and swap handshake. Double buffering: FRAME_SCANOUT_DOUBLE_BUFFER_EN.
module frame_scanout
  import scanout_pkg::*;
#(
  parameter int COOR_WIDTH   = DEF_COOR_WIDTH,
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int VIEW_Y0      = DEF_VIEW_Y0,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic [COOR_WIDTH-1:0] scroll_x,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  read_buf,
  output logic [COOR_WIDTH-1:0] read_x,
  output logic [COOR_WIDTH-1:0] read_y,
  input  logic [2:0]            read_palette,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [23:0]           rgb
);

  localparam int unsigned AW = COOR_WIDTH + 1;
  localparam logic [COOR_WIDTH:0]   FRAME_W_C = AW'(FRAME_WIDTH);
  localparam logic [COOR_WIDTH-1:0] Y0_C      = COOR_WIDTH'(VIEW_Y0);
  localparam logic [COOR_WIDTH-1:0] Y_END_C   = COOR_WIDTH'(VIEW_Y0 + FRAME_HEIGHT);

  logic [COOR_WIDTH-1:0] h, v;
  logic                  active, hsync_n, vsync_n, vblank_start;

  scanout_timing #(
    .COOR_WIDTH (COOR_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP)
  ) u_timing (
    .clk_33m        (clk_33m),
    .rst            (rst),
    .h_o            (h),
    .v_o            (v),
    .active_o       (active),
    .hsync_n_o      (hsync_n),
    .vsync_n_o      (vsync_n),
    .vblank_start_o (vblank_start)
  );

  // Stage 0: combinational read address
  logic                  in_band;
  logic [COOR_WIDTH-1:0] sx_q, sx_d;
  logic [COOR_WIDTH:0]   x_sum, x_sel;

  assign in_band = active && (v >= Y0_C) && (v < Y_END_C);

  always_comb begin
    x_sum  = {1'b0, sx_q} + {1'b0, h};
    x_sel  = (x_sum >= FRAME_W_C) ? x_sum - FRAME_W_C : x_sum;
    read_x = '0;
    read_y = '0;
    if (in_band) begin
      read_x = COOR_WIDTH'(x_sel);
      read_y = v - Y0_C;
    end
  end

  // Out-of-range scroll offsets restart the window at column 0.
  always_comb begin
    sx_d = sx_q;
    if (vblank_start) sx_d = ({1'b0, scroll_x} >= FRAME_W_C) ? '0 : scroll_x;
  end

  // Stage 1 delays the control terms to meet the RAM data; stage 2 drives the panel.
  pipe_ctl_t s1_q;
  rgb_t      rgb_q, rgb_d;
  logic      de_q, hsync_q, vsync_q;
  logic      swap_ack_q, swap_ack_d;

  assign rgb_d      = s1_q.in_band ? PALETTE[read_palette] : PALETTE[0];
  assign swap_ack_d = vblank_start && swap_req;

  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      sx_q       <= '0;
      s1_q       <= PIPE_IDLE;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      swap_ack_q <= 1'b0;
    end else begin
      sx_q       <= sx_d;
      s1_q       <= '{in_band: in_band, active: active, hsync_n: hsync_n, vsync_n: vsync_n};
      rgb_q      <= rgb_d;
      de_q       <= s1_q.active;
      hsync_q    <= s1_q.hsync_n;
      vsync_q    <= s1_q.vsync_n;
      swap_ack_q <= swap_ack_d;
    end
  end

`ifdef FRAME_SCANOUT_DOUBLE_BUFFER_EN
  logic read_buf_q;

  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) read_buf_q <= 1'b0;
    else     read_buf_q <= read_buf_q ^ swap_ack_d;
  end

  assign read_buf = read_buf_q;
`else
  // Single buffer: the ack still serves the painter as a frame-sync strobe.
  assign read_buf = 1'b0;
`endif

  assign swap_ack = swap_ack_q;
  assign rgb      = rgb_q;
  assign de       = de_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Display-side reader of the frame buffer that `paint_element` writes. It generates 800x480 panel timing on `clk_33m` and reads one 3-bit palette index per active pixel from the external frame RAM (1-cycle synchronous read). It maps each index through a fixed palette to 24-bit RGB. It also owns the double-buffer swap handshake with the painting side and latches a horizontal scroll offset once per frame.

## Interface
Parameters:
- `COOR_WIDTH`, 12: coordinate width.
- `FRAME_WIDTH`, 1280: frame buffer width in pixels.
- `FRAME_HEIGHT`, 300: frame buffer height in pixels.
- `VIEW_Y0`, 90: first display line that shows frame row 0.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 800/40/128/88: horizontal timing; total is 1056.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing; total is 525.

Ports:
- `clk_33m`, in, 1: pixel clock, the block's only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `scroll_x`, in, COOR_WIDTH: horizontal window offset into the frame.
- `swap_req`, in, 1: level request from the painter to swap buffers.
- `swap_ack`, out, 1: one-cycle pulse when a swap has been performed.
- `read_buf`, out, 1: buffer currently being scanned out; the painter writes the other one.
- `read_x`, out, COOR_WIDTH: frame RAM read column.
- `read_y`, out, COOR_WIDTH: frame RAM read row.
- `read_palette`, in, 3: RAM data; valid one cycle after the address.
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `de`, out, 1: data enable.
- `rgb`, out, 24: pixel colour as {R[7:0], G[7:0], B[7:0]}.

## Operation
- Counters: `h` runs 0..1055, then wraps to 0 and increments `v`. `v` runs 0..524, then wraps to 0.
- Active region: `h < H_ACTIVE && v < V_ACTIVE`.
- Sync windows:
  - `hsync` is low for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - `vsync` is low for `v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Band: `v` in [VIEW_Y0, VIEW_Y0+FRAME_HEIGHT) and active. Inside the band, the RAM is read. Outside the band, or during blanking, the pixel colour is palette entry 0 (background).
- Address generation, computed in COOR_WIDTH+1 bits:
  - `read_x = sx + h`. If the sum is ≥ FRAME_WIDTH, subtract FRAME_WIDTH (single wrap).
  - `read_y = v - VIEW_Y0`.
  - When not in the band, `read_x` and `read_y` are 0.
- Scroll latch: `sx` samples `scroll_x` at `h==0, v==V_ACTIVE` (vblank start). A sampled value ≥ FRAME_WIDTH latches as 0. Reset value of `sx` is 0.
- Swap handshake:
  - At vblank start, if `swap_req` is high, toggle `read_buf` and pulse `swap_ack` for that one cycle.
  - `swap_req` stays pending across frames until it is served.
  - The painter must drop `swap_req` after seeing the ack. If `swap_req` is still high at the next vblank start, a second swap occurs.
  - A `swap_req` that rises in the vblank-start cycle itself is served in that cycle.

## Timing
- Stage 0: counters, then combinational address to the RAM.
- Stage 1: RAM data arrives; `in_band`, `active` and the sync terms are delayed one cycle to match.
- Stage 2: palette lookup; `rgb`, `de`, `hsync` and `vsync` are all registered outputs.
- Outputs lag the counters by exactly 2 cycles, and sync/de/rgb stay mutually aligned.
- `swap_ack` and `read_buf` are registered and change on the cycle after vblank start is decoded.
- Reset values (asynchronous): `h=v=0`, `hsync=vsync=1`, `de=0`, `rgb=0`, `read_x=read_y=0`, `read_buf=0`, `swap_ack=0`, pipeline flops cleared.
- Reset asserted mid-frame aborts the frame immediately. Scanning restarts from `h=v=0` on the first edge after release.

## Configuration
- `FRAME_SCANOUT_DOUBLE_BUFFER_EN` defined: swap behaviour as above; `read_buf` toggles.
- Undefined:
  - `read_buf` is tied to 0.
  - `swap_ack` still pulses at every vblank start where `swap_req` is high, so the painter can use it as a frame-sync.
  - No buffer toggling occurs.

## Structure
- Package `scanout_pkg`:
  - Typedef `rgb_t` (packed 24-bit).
  - Palette constant `PALETTE[8]` of `rgb_t`; entry 0 is background.
  - Default timing constants.
- Sub-module `scanout_timing`: h/v counters plus `active`, `hsync_n`, `vsync_n` and the `vblank_start` strobe.
- `frame_scanout` holds address generation, the pipeline, the scroll latch and the swap handshake.

## Test plan
- Reset: hold `rst` for 3 cycles and check every output equals its reset value. Release, then at cycle 2 after release expect `de=1`, `rgb=PALETTE[0]`, `hsync=vsync=1`.
- Band edge: at `v=89` expect `read_x=read_y=0` and `rgb=PALETTE[0]`. At `v=90, h=0`, with `sx=0`, expect `read_y=0, read_x=0`. RAM returns 5, so `rgb=PALETTE[5]` 2 cycles later.
- Scroll wrap: set `scroll_x=1000` before vblank. In the next frame, `h=279` gives `read_x=1279` and `h=280` gives `read_x=0`. A `scroll_x=1300` latch gives `sx=0`.
- Sync alignment: `hsync` is low for 128 cycles starting 2 cycles after `h=840`. `vsync` is low for 2 full lines starting at `v=490`. Frame period is 554400 cycles.
- Swap: raise `swap_req` at `v=100`. Expect exactly one `swap_ack` pulse and a `read_buf` 0→1 transition at the vblank start that follows. Dropping the request after the ack leaves no further swap. Holding it gives a toggle every frame.
- Mid-frame reset: assert `rst` at `v=200, h=400` with `read_buf=1`. Outputs return to reset values asynchronously and `read_buf=0`. Scan restarts at `h=v=0`.
